// File: rtl/ftdi_fifo_reader_pkg.sv
// Shared definitions for the FTDI FIFO read front end: FSM states and
// active-low bus levels used by the handshake logic.
package ftdi_fifo_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OE   = 2'd1,
        ST_READ = 2'd2
    } state_e;

    localparam logic FTDI_ACTIVE   = 1'b0;
    localparam logic FTDI_INACTIVE = 1'b1;

    localparam int WORD_W_DEFAULT = 16;
    localparam int BE_W           = 2;

endpackage

// File: rtl/ftdi_fifo_reader_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head word is visible on dout
// whenever empty is low, and reads as zero while empty.
module sync_fifo_fwft
    import ftdi_fifo_reader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on each pointer distinguishes full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ftdi_fifo_reader.sv
// FT600-style synchronous FIFO reader: drives OE_N/RD_N, captures words into
// a FWFT buffer and streams them out as valid/ready words.
module ftdi_fifo_reader
    import ftdi_fifo_reader_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2,
    parameter int WORD_W       = WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ftdi_rxf_n,
    input  logic [WORD_W-1:0] ftdi_data,
    input  logic [BE_W-1:0]   ftdi_be,
    output logic              ftdi_oe_n,
    output logic              ftdi_rd_n,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       word_count,
    output logic              partial_seen,
    output logic              overflow
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int LANE_W = WORD_W / BE_W;

    state_e            state_q;
    logic              oe_n_q;
    logic              rd_n_q;
    logic [31:0]       word_count_q;
    logic              partial_q;
    logic              overflow_q;

    logic [WORD_W-1:0] masked_data;
    logic              capture;
    logic              push;
    logic              pop;
    logic              flush;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    int                occ_d;
    int                free_d;
    logic              rxf_active;

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            assign masked_data[gi*LANE_W +: LANE_W] =
                ftdi_be[gi] ? ftdi_data[gi*LANE_W +: LANE_W] : '0;
        end
    endgenerate

    assign rxf_active = (ftdi_rxf_n == FTDI_ACTIVE);
    assign capture    = (rd_n_q == FTDI_ACTIVE) && rxf_active && enable;
    assign flush      = !enable;
    assign push       = capture && !fifo_full;
    assign pop        = m_ready && !fifo_empty && enable;

    // Free space as it will be after this edge's push/pop (or flush).
    always_comb begin
        occ_d = 0;
        if (!flush) begin
            occ_d = int'(fifo_count) + (push ? 1 : 0) - (pop ? 1 : 0);
        end
        free_d = DEPTH - occ_d;
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (masked_data),
        .dout  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            oe_n_q       <= FTDI_INACTIVE;
            rd_n_q       <= FTDI_INACTIVE;
            word_count_q <= '0;
            partial_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (flush) begin
                word_count_q <= '0;
            end else if (push) begin
                word_count_q <= word_count_q + 32'd1;
            end
            if (capture && (ftdi_be != 2'b11)) begin
                partial_q <= 1'b1;
            end
            if (capture && fifo_full) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable && rxf_active && free_d >= AFULL_MARGIN + 1) begin
                        state_q <= ST_OE;
                        oe_n_q  <= FTDI_ACTIVE;
                        rd_n_q  <= FTDI_INACTIVE;
                    end else begin
                        oe_n_q  <= FTDI_INACTIVE;
                        rd_n_q  <= FTDI_INACTIVE;
                    end
                end
                ST_OE: begin
                    if (enable) begin
                        state_q <= ST_READ;
                        oe_n_q  <= FTDI_ACTIVE;
                        rd_n_q  <= FTDI_ACTIVE;
                    end else begin
                        state_q <= ST_IDLE;
                        oe_n_q  <= FTDI_INACTIVE;
                        rd_n_q  <= FTDI_INACTIVE;
                    end
                end
                ST_READ: begin
                    if (enable && rxf_active && free_d >= AFULL_MARGIN) begin
                        oe_n_q  <= FTDI_ACTIVE;
                        rd_n_q  <= FTDI_ACTIVE;
                    end else begin
                        state_q <= ST_IDLE;
                        oe_n_q  <= FTDI_INACTIVE;
                        rd_n_q  <= FTDI_INACTIVE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    oe_n_q  <= FTDI_INACTIVE;
                    rd_n_q  <= FTDI_INACTIVE;
                end
            endcase
        end
    end

    assign ftdi_oe_n    = oe_n_q;
    assign ftdi_rd_n    = rd_n_q;
    assign m_valid      = !fifo_empty;
    assign word_count   = word_count_q;
    assign partial_seen = partial_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ftdi_fifo_reader.sv
// Bench for ftdi_fifo_reader: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the buffer and bus rules.
module tb_ftdi_fifo_reader;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ftdi_rxf_n;
    logic [15:0] ftdi_data;
    logic [1:0]  ftdi_be;
    logic        ftdi_oe_n;
    logic        ftdi_rd_n;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] word_count;
    logic        partial_seen;
    logic        overflow;

    always #5 clk = ~clk;

    ftdi_fifo_reader #(
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (MARGIN),
        .WORD_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .ftdi_rxf_n   (ftdi_rxf_n),
        .ftdi_data    (ftdi_data),
        .ftdi_be      (ftdi_be),
        .ftdi_oe_n    (ftdi_oe_n),
        .ftdi_rd_n    (ftdi_rd_n),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .word_count   (word_count),
        .partial_seen (partial_seen),
        .overflow     (overflow)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [31:0] exp_count;
    logic        exp_partial;
    logic        exp_ovf;
    logic        exp_oe_n;
    logic        exp_rd_n;
    bit          rand_mode;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_count   = 0;
        exp_partial = 1'b0;
        exp_ovf     = 1'b0;
        exp_oe_n    = 1'b1;
        exp_rd_n    = 1'b1;
    endtask

    // Check outputs against the model, advance one clock, then update the model
    // from the inputs that were present at that edge.
    task automatic step();
        logic        p_rst, p_en, p_rxf, p_rdy, cap, room, stay, go;
        logic [15:0] p_data;
        logic [1:0]  p_be;
        int          free_after;
        check_val("oe_n", ftdi_oe_n, exp_oe_n);
        check_val("rd_n", ftdi_rd_n, exp_rd_n);
        check_val("m_valid", m_valid, (exp_q.size() != 0) ? 32'd1 : 32'd0);
        if (exp_q.size() != 0) check_val("m_data", m_data, exp_q[0]);
        check_val("word_count", word_count, exp_count);
        check_val("partial_seen", partial_seen, exp_partial);
        check_val("overflow", overflow, exp_ovf);
        p_rst = rst; p_en = enable; p_rxf = ftdi_rxf_n; p_rdy = m_ready;
        p_data = ftdi_data; p_be = ftdi_be;
        @(posedge clk);
        #1;
        if (p_rst) begin
            model_reset();
        end else if (!p_en) begin
            exp_q.delete();
            exp_count = 0;
            exp_oe_n  = 1'b1;
            exp_rd_n  = 1'b1;
        end else begin
            cap  = !exp_rd_n && !p_rxf;
            room = exp_q.size() < DEPTH;
            if (p_rdy && exp_q.size() != 0) void'(exp_q.pop_front());
            if (cap) begin
                if (p_be != 2'b11) exp_partial = 1'b1;
                if (room) begin
                    exp_q.push_back({p_be[1] ? p_data[15:8] : 8'h00,
                                     p_be[0] ? p_data[7:0]  : 8'h00});
                    exp_count = exp_count + 1;
                end else begin
                    exp_ovf = 1'b1;
                end
                ftdi_data = rand_mode ? 16'($urandom) : p_data + 16'h1111;
            end
            free_after = DEPTH - exp_q.size();
            if (!exp_rd_n) begin
                stay     = !p_rxf && (free_after >= MARGIN);
                exp_rd_n = !stay;
                exp_oe_n = !stay;
            end else if (!exp_oe_n) begin
                exp_rd_n = 1'b0;
            end else begin
                go       = !p_rxf && (free_after >= MARGIN + 1);
                exp_oe_n = !go;
            end
        end
    endtask

    initial begin
        int   guard;
        logic seen;
        rst = 1'b1; enable = 1'b0; ftdi_rxf_n = 1'b1; m_ready = 1'b0;
        ftdi_data = 16'h1111; ftdi_be = 2'b11; rand_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_oe_n", ftdi_oe_n, 1);
        check_val("rst_rd_n", ftdi_rd_n, 1);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_data", m_data, 0);
        check_val("rst_word_count", word_count, 0);
        rst = 1'b0;

        // 1: five-word burst, streamed straight through
        enable = 1'b1; m_ready = 1'b1;
        step(); step();
        ftdi_rxf_n = 1'b0;
        guard = 0;
        while (exp_count < 5 && guard < 20) begin step(); guard++; end
        ftdi_rxf_n = 1'b1;
        repeat (4) step();
        check_val("t1_word_count", word_count, 5);
        $display("[TB] test1 burst of 5 done, word_count=%0d", word_count);

        // 2: back-pressure fills to DEPTH-1, then drain restarts reads
        enable = 1'b0; step();
        enable = 1'b1; m_ready = 1'b0; ftdi_rxf_n = 1'b0;
        repeat (16) step();
        check_val("t2_word_count", word_count, 7);
        check_val("t2_rd_idle", ftdi_rd_n, 1);
        check_val("t2_overflow", overflow, 0);
        m_ready = 1'b1;
        seen = 1'b0; guard = 0;
        while (!seen && guard < 12) begin
            step(); guard++;
            if (ftdi_rd_n == 1'b0) seen = 1'b1;
        end
        check_val("t2_reburst", seen, 1);
        repeat (10) step();
        $display("[TB] test2 back-pressure done, word_count=%0d", word_count);

        // 3: single-cycle RXF_N glitch mid-burst
        repeat (6) step();
        ftdi_rxf_n = 1'b1; step();
        ftdi_rxf_n = 1'b0; repeat (8) step();
        ftdi_rxf_n = 1'b1; repeat (4) step();
        $display("[TB] test3 rxf glitch done, word_count=%0d", word_count);

        // 4: partial byte enables
        enable = 1'b0; step();
        enable = 1'b1; m_ready = 1'b0; ftdi_data = 16'hABCD; ftdi_be = 2'b01; ftdi_rxf_n = 1'b0;
        guard = 0;
        while (exp_count < 1 && guard < 6) begin step(); guard++; end
        ftdi_be = 2'b11; ftdi_rxf_n = 1'b1;
        step();
        check_val("t4_data", m_data, 16'h00CD);
        check_val("t4_partial", partial_seen, 1);
        enable = 1'b0; step(); step();
        enable = 1'b1; step();
        check_val("t4_partial_sticky", partial_seen, 1);
        $display("[TB] test4 partial word done, m_data=0x%h", m_data);

        // 5: reset in the middle of a read burst
        enable = 1'b0; step();
        enable = 1'b1; m_ready = 1'b0; ftdi_rxf_n = 1'b0;
        guard = 0;
        while (exp_count < 3 && guard < 10) begin step(); guard++; end
        check_val("t5_in_read", ftdi_rd_n, 0);
        rst = 1'b1; step(); rst = 1'b0;
        check_val("t5_oe_n", ftdi_oe_n, 1);
        check_val("t5_rd_n", ftdi_rd_n, 1);
        check_val("t5_m_valid", m_valid, 0);
        check_val("t5_m_data", m_data, 0);
        check_val("t5_word_count", word_count, 0);
        repeat (4) step();
        $display("[TB] test5 mid-burst reset done");

        // 6: disabled with data pending, then re-enable
        enable = 1'b0; ftdi_rxf_n = 1'b0; m_ready = 1'b0;
        repeat (10) step();
        check_val("t6_word_count", word_count, 0);
        check_val("t6_m_valid", m_valid, 0);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (ftdi_rd_n == 1'b0) seen = 1'b1;
        end
        check_val("t6_restart", seen, 1);
        $display("[TB] test6 enable gating done");

        // Random traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 499) == 0);
            enable     = ($urandom_range(0, 63) != 0);
            ftdi_rxf_n = ($urandom_range(0, 3) == 0);
            m_ready    = ($urandom_range(0, 2) != 0);
            ftdi_be    = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            step();
        end
        rst = 1'b0; enable = 1'b1; ftdi_rxf_n = 1'b1; m_ready = 1'b1;
        repeat (12) step();
        $display("[TB] random phase done, word_count=%0d", word_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
